// File: rtl/rom_fetch_unit_if.sv
// Instruction stream between the ROM fetch unit and its consumer.
// No latency of its own; wires only.
// Backpressure: the consumer holds instr_ready low to stall the head word.
interface rom_fetch_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_addr;

  // Producer side (the fetch unit)
  modport master (
    output instr_valid,
    output instr_data,
    output instr_addr,
    input  instr_ready
  );

  // Consumer side
  modport slave (
    input  instr_valid,
    input  instr_data,
    input  instr_addr,
    output instr_ready
  );
endinterface

// File: rtl/rom_fetch_unit.sv
// Sequencer in front of a synchronous-read ROM: issues addresses, buffers words in a 2-entry FIFO.
// Latency: issue at t, ROM data at t+1, instr_valid at t+2; a start pulse gives the first word 3 cycles later.
// Backpressure: issue stalls when the FIFO plus the in-flight read would exceed 2 entries; no word is ever lost.
module rom_fetch_unit #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int LAST_ADDR = 15,
  parameter int LOOP      = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  rom_fetch_unit_if.master  instr,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;

  logic [DATA_W-1:0] fifo_data [2];
  logic [ADDR_W-1:0] fifo_addr [2];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        occ;

  logic              redir, pop, push, issue;
  logic [2:0]        demand;

  // Out-of-range redirects are treated as if they never happened.
  assign redir  = redirect_valid && (redirect_addr <= LAST);
  assign pop    = instr.instr_valid && instr.instr_ready;
  // A redirect kills the read that is still in flight.
  assign push   = pend && !redir;
  // Slots the FIFO will need after this cycle's pop; issuing is safe while at most one is taken.
  assign demand = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
  assign issue  = (state == FETCH) && !redir && (demand <= 3'd1);

  // Next-state, next-pc and the done pulse; a valid redirect overrides everything.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    done      = 1'b0;
    if (redir) begin
      state_nxt = FETCH;
      pc_nxt    = redirect_addr;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = FETCH;
            pc_nxt    = '0;
          end
        end
        FETCH: begin
          if (issue) begin
            if (pc == LAST) begin
              if (LOOP != 0) pc_nxt = '0;
              else           state_nxt = DRAIN;
            end else begin
              pc_nxt = pc + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (occ == 2'd0 && !pend) begin
            state_nxt = IDLE;
            done      = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, pc and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      pend  <= issue;
      if (issue) pend_addr <= pc;
    end
  end

  // Two-entry word buffer; push and pop may coincide at any occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else if (redir) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= rom_data;
        fifo_addr[wr_ptr] <= pend_addr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign rom_addr          = pc;
  assign busy              = (state != IDLE);
  assign instr.instr_valid = (occ != 2'd0);
  assign instr.instr_data  = fifo_data[rd_ptr];
  assign instr.instr_addr  = fifo_addr[rd_ptr];

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: a stop-at-end instance and a looping instance, each with a ROM holding mem[i]=i+1.
// Stream checks compare every accepted word against the expected address sequence.
// Waits are bounded by cycle budgets and a global watchdog.
module tb_rom_fetch_unit;

  logic        clk;
  logic        rst;
  logic        start, start1;
  logic        redirect_valid, redir1_valid;
  logic [4:0]  redirect_addr, redir1_addr;
  logic [4:0]  rom_addr, rom_addr1;
  logic [31:0] rom_data, rom_data1;
  logic        busy, busy1, done, done1;
  logic        ready;

  int checks = 0;
  int errors = 0;

  rom_fetch_unit_if #(.ADDR_W(5), .DATA_W(32)) if0 ();
  rom_fetch_unit_if #(.ADDR_W(5), .DATA_W(32)) if1 ();

  assign if0.instr_ready = ready;
  assign if1.instr_ready = 1'b1;

  rom_fetch_unit #(.ADDR_W(5), .DATA_W(32), .LAST_ADDR(15), .LOOP(0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .instr(if0.master), .busy(busy), .done(done)
  );

  rom_fetch_unit #(.ADDR_W(5), .DATA_W(32), .LAST_ADDR(15), .LOOP(1)) dut_loop (
    .clk(clk), .rst(rst), .start(start1),
    .redirect_valid(redir1_valid), .redirect_addr(redir1_addr),
    .rom_addr(rom_addr1), .rom_data(rom_data1),
    .instr(if1.master), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read ROMs, mem[i] = i + 1
  always @(posedge clk) begin
    rom_data  <= 32'(rom_addr) + 32'd1;
    rom_data1 <= 32'(rom_addr1) + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doreset();
    rst = 1'b1;
    start = 1'b0;
    start1 = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    redir1_valid = 1'b0;
    redir1_addr = '0;
    ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Consume with ready high, expect addresses first..last back to back, one done, then idle.
  task automatic stream(input string tag, input int first, input int last, input int budget);
    int exp = first;
    int cyc = 0;
    int dones = 0;
    int extra = 0;
    bit seen = 1'b0;
    bit bubble = 1'b0;
    ready = 1'b1;
    while (!(exp > last && !busy) && cyc < budget) begin
      if (done) dones++;
      if (if0.instr_valid) begin
        if (exp <= last) begin
          chk({tag, "_addr"}, 32'(if0.instr_addr), 32'(exp));
          chk({tag, "_data"}, if0.instr_data, 32'(exp + 1));
        end else begin
          extra++;
        end
        seen = 1'b1;
        exp++;
      end else if (seen && exp <= last) begin
        bubble = 1'b1;
      end
      tick();
      cyc++;
    end
    chk({tag, "_in_budget"}, 32'(cyc < budget), 32'd1);
    chk({tag, "_bubble"}, 32'(bubble), 32'd0);
    chk({tag, "_extra_words"}, 32'(extra), 32'd0);
    chk({tag, "_done_pulses"}, 32'(dones), 32'd1);
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [4:0]  exp_rom;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // Backpressure run: start at cycle 0, ready low in cycles 3..7.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1, 5'd2, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1, 5'd2, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1, 5'd2, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1, 5'd2, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 5'd0, 32'd1, 5'd2, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'd0, 32'd1, 5'd2, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 5'd1, 32'd2, 5'd3, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 5'd2, 32'd3, 5'd4, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 5'd3, 32'd4, 5'd5, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 5'd4, 32'd5, 5'd6, 1'b1};

    // Reset state, then plain run with ready always high
    doreset();
    chk("rst_valid", 32'(if0.instr_valid), 32'd0);
    chk("rst_data", if0.instr_data, 32'd0);
    chk("rst_addr", 32'(if0.instr_addr), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_c1_valid", 32'(if0.instr_valid), 32'd0);
    tick();
    chk("run_c2_valid", 32'(if0.instr_valid), 32'd0);
    tick();
    chk("run_c3_valid", 32'(if0.instr_valid), 32'd1);
    stream("run", 0, 15, 60);
    chk("run_idle_busy", 32'(busy), 32'd0);

    // Backpressure table
    doreset();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("bp%0d_valid", i), 32'(if0.instr_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("bp%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].exp_rom));
      chk($sformatf("bp%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      if (vecs[i].exp_valid) begin
        chk($sformatf("bp%0d_addr", i), 32'(if0.instr_addr), 32'(vecs[i].exp_addr));
        chk($sformatf("bp%0d_data", i), if0.instr_data, vecs[i].exp_data);
      end
      start = vecs[i].start;
      ready = vecs[i].ready;
      tick();
    end
    stream("bp", 5, 15, 60);

    // Redirect to 10 while head is (3,4) with a read in flight
    doreset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("redir_head_addr", 32'(if0.instr_addr), 32'd3);
    chk("redir_head_data", if0.instr_data, 32'd4);
    redirect_valid = 1'b1;
    redirect_addr = 5'd10;
    tick();
    redirect_valid = 1'b0;
    chk("redir_r1_valid", 32'(if0.instr_valid), 32'd0);
    tick();
    chk("redir_r2_valid", 32'(if0.instr_valid), 32'd0);
    tick();
    chk("redir_r3_valid", 32'(if0.instr_valid), 32'd1);
    stream("redir", 10, 15, 40);

    // Out-of-range redirect and start during FETCH are both ignored
    doreset();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("ign_c5_addr", 32'(if0.instr_addr), 32'd2);
    redirect_valid = 1'b1;
    redirect_addr = 5'd20;
    tick();
    redirect_valid = 1'b0;
    start = 1'b1;
    chk("ign_c6_addr", 32'(if0.instr_addr), 32'd3);
    chk("ign_c6_valid", 32'(if0.instr_valid), 32'd1);
    tick();
    start = 1'b0;
    stream("ign", 4, 15, 60);

    // Reset while the FIFO is full
    doreset();
    ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("full_valid", 32'(if0.instr_valid), 32'd1);
    chk("full_rom_addr", 32'(rom_addr), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(if0.instr_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("restart_c3_valid", 32'(if0.instr_valid), 32'd1);
    stream("restart", 0, 15, 60);

    // Looping instance: continuous stream across the wrap, no done
    doreset();
    begin
      int dones1 = 0;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 40; i++) begin
        chk($sformatf("loop%0d_valid", i), 32'(if1.instr_valid), 32'd1);
        chk($sformatf("loop%0d_addr", i), 32'(if1.instr_addr), 32'(i % 16));
        chk($sformatf("loop%0d_data", i), if1.instr_data, 32'((i % 16) + 1));
        if (done1) dones1++;
        tick();
      end
      chk("loop_done_pulses", 32'(dones1), 32'd0);
      chk("loop_busy", 32'(busy1), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_fetch_unit.md
Name: rom_fetch_unit

Overview:
- Sequencer that sits in front of the 16x32 synchronous-read ROM.
- Drives the ROM address, tracks the 1-cycle ROM read latency, and buffers returned words in a 2-entry FIFO.
- Presents the words to the downstream consumer as a valid/ready stream tagged with their address.
- Supports start, redirect (branch-style flush) and end-of-ROM stop or loop.

Parameters:
- ADDR_W, 5, ROM address width.
- DATA_W, 32, ROM word width.
- LAST_ADDR, 15, highest valid ROM address.
- LOOP, 0, 1 = wrap to 0 after LAST_ADDR; 0 = stop after LAST_ADDR.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: begin fetching at address 0 (honoured only in IDLE).
- redirect_valid  in  1  flush the pipeline and restart at redirect_addr.
- redirect_addr  in  ADDR_W  restart address.
- rom_addr  out  ADDR_W  address to ROM (registered).
- rom_data  in  DATA_W  ROM read data, valid the cycle after an issue.
- instr_valid  out  1  FIFO head valid.
- instr_ready  in  1  consumer accepts head.
- instr_data  out  DATA_W  head word.
- instr_addr  out  ADDR_W  address the head word was read from.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on DRAIN->IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset values: rom_addr=0, instr_valid=0, instr_data=0, instr_addr=0, busy=0, done=0. FIFO is emptied, pend=0, state=IDLE.
- rst mid-operation discards all in-flight and buffered data.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - start=1 -> FETCH, pc<=0.
  - redirect_valid=1 with redirect_addr<=LAST_ADDR -> FETCH, pc<=redirect_addr.
  - If start and redirect arrive together, redirect wins.
- rom_addr always equals the pc register.
- Issue happens in a cycle when state==FETCH and (occ + pend - pop) <= 1.
  - occ: FIFO occupancy, 0..2.
  - pend: a read issued last cycle.
  - pop: instr_valid & instr_ready.
  - This guarantees no FIFO overflow and full throughput (one word per cycle) when instr_ready is held high.
- On issue:
  - pend<=1 and the address is recorded.
  - If pc==LAST_ADDR: LOOP=1 -> pc<=0; LOOP=0 -> state<=DRAIN.
  - Otherwise pc<=pc+1.
- If pend=1, rom_data and the recorded address are pushed into the FIFO at the end of that cycle.
- Latency: issue at cycle t, ROM data in cycle t+1, instr_valid in cycle t+2. The start pulse at cycle 0 gives the first instr_valid at cycle 3.
- Stream rules:
  - instr_data and instr_addr hold stable while instr_valid=1 and instr_ready=0.
  - A simultaneous push and pop is allowed at any occupancy.
- DRAIN: no issues. When occ==0 and pend==0 -> IDLE with done=1 for one cycle.
- redirect_valid in FETCH or DRAIN (and redirect_addr<=LAST_ADDR):
  - FIFO is cleared and any pending read is dropped (not pushed).
  - pc<=redirect_addr, state<=FETCH.
  - A pop handshake in the redirect cycle counts as a completed transfer.
  - instr_valid=0 the next cycle.
  - The first redirected word appears 3 cycles after the redirect cycle.
- redirect_valid with redirect_addr>LAST_ADDR is ignored entirely.
- start outside IDLE is ignored.

Test Plan:
- ROM contents are mem[i]=i+1.
- Reset, start pulse, instr_ready=1, LOOP=0:
  - instr_valid from cycle 3 for 16 consecutive cycles.
  - Outputs (addr,data) = (0,1)...(15,0x10).
  - done pulses once, then busy=0.
- Backpressure: instr_ready low for 5 cycles after the first word:
  - Head holds (0,1) stably.
  - rom_addr stops advancing at 2.
  - No word is lost or duplicated on release.
  - Sequence continues (1,2),(2,3)...
- Redirect to 10 while head is (3,4) with pend=1:
  - Pending word is dropped and instr_valid=0 next cycle.
  - Next words are (10,0xB),(11,0xC)...(15,0x10), then done.
- LOOP=1, ready always 1: after (15,0x10) the next word is (0,1) with no bubble, and done never pulses.
- rst asserted while occ=2:
  - Next cycle instr_valid=0, busy=0, rom_addr=0.
  - A subsequent start restarts at (0,1).
- redirect_addr=20 in FETCH: ignored, stream continues uninterrupted. Start during FETCH: ignored.
